// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register in-flight write counters driving the ID-stage stall,
// with a load-use check when forwarding is enabled.
module hazard_scoreboard #(
    parameter int NUM_REGS = 16,
    parameter int CNT_W    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        Forwarding_Enable,
    input  logic                        issue_valid,
    input  logic                        issue_wb_en,
    input  logic                        issue_is_load,
    input  logic [$clog2(NUM_REGS)-1:0] issue_dest,
    input  logic [$clog2(NUM_REGS)-1:0] src1,
    input  logic [$clog2(NUM_REGS)-1:0] src2,
    input  logic                        use_src2,
    input  logic                        WB_EN,
    input  logic [$clog2(NUM_REGS)-1:0] WB_Dest,
    output logic                        hazard,
    output logic [NUM_REGS-1:0]         busy_mask,
    output logic                        underflow_err
);
    localparam int IW = $clog2(NUM_REGS);

    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];
    logic             ld_valid_q, ld_valid_d;
    logic [IW-1:0]    ld_dest_q, ld_dest_d;
    logic             underflow_q, underflow_d;
    logic             s1_rdy, s2_rdy, full, stall_nofwd, stall_fwd, accept;

    // A count of 1 being retired this cycle is readable thanks to the write-first register file.
    always_comb begin
        s1_rdy      = cnt_q[src1] == '0 || (cnt_q[src1] == CNT_W'(1) && WB_EN && WB_Dest == src1);
        s2_rdy      = cnt_q[src2] == '0 || (cnt_q[src2] == CNT_W'(1) && WB_EN && WB_Dest == src2);
        full        = issue_valid && issue_wb_en && cnt_q[issue_dest] == '1;
        stall_nofwd = !Forwarding_Enable && issue_valid && (!s1_rdy || (use_src2 && !s2_rdy));
        stall_fwd   = Forwarding_Enable && issue_valid && ld_valid_q
                      && (ld_dest_q == src1 || (use_src2 && ld_dest_q == src2));
        hazard      = full || stall_nofwd || stall_fwd;
        accept      = issue_valid && !hazard;
        ld_valid_d  = accept && issue_is_load && issue_wb_en;
        ld_dest_d   = ld_valid_d ? issue_dest : ld_dest_q;
        underflow_d = underflow_q || (WB_EN && cnt_q[WB_Dest] == '0);
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d[i]     = cnt_q[i];
            busy_mask[i] = cnt_q[i] != '0;
            if ((accept && issue_wb_en && issue_dest == IW'(i))
                != (WB_EN && WB_Dest == IW'(i) && cnt_q[i] != '0))
                cnt_d[i] = (accept && issue_wb_en && issue_dest == IW'(i)) ? cnt_q[i] + 1'b1
                                                                         : cnt_q[i] - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '{default: '0};
            ld_valid_q  <= 1'b0;
            ld_dest_q   <= '0;
            underflow_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            ld_valid_q  <= ld_valid_d;
            ld_dest_q   <= ld_dest_d;
            underflow_q <= underflow_d;
        end
    end

    assign underflow_err = underflow_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed and random stimulus checked by a queue-based scoreboard
// against a list-of-in-flight-writes reference model.
module tb_hazard_scoreboard;
    logic        clk = 0;
    logic        rst = 1, fe = 0, iv = 0, iwb = 0, ild = 0, us2 = 0, wbe = 0;
    logic [3:0]  id = 0, s1 = 0, s2 = 0, wbd = 0;
    logic        hz, uf;
    logic [15:0] bm;

    typedef struct {
        string       nm;
        logic        hz;
        logic [15:0] bm;
        logic        uf;
    } exp_t;

    exp_t sb[$];
    int   inflight[$];
    bit   m_ldv, m_uf;
    int   m_ldd;
    int   tests = 0, failed = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst), .Forwarding_Enable(fe), .issue_valid(iv), .issue_wb_en(iwb),
        .issue_is_load(ild), .issue_dest(id), .src1(s1), .src2(s2), .use_src2(us2),
        .WB_EN(wbe), .WB_Dest(wbd), .hazard(hz), .busy_mask(bm), .underflow_err(uf)
    );

    function automatic int cnt_of(int r);
        int n = 0;
        foreach (inflight[k]) if (inflight[k] == r) n++;
        return n;
    endfunction

    function automatic bit rdy(int s);
        return cnt_of(s) == 0 || (cnt_of(s) == 1 && wbe && int'(wbd) == s);
    endfunction

    function automatic bit m_hazard();
        if (!iv) return 0;
        if (iwb && cnt_of(int'(id)) >= 3) return 1;
        if (fe) return m_ldv && (m_ldd == int'(s1) || (us2 && m_ldd == int'(s2)));
        return !rdy(int'(s1)) || (us2 && !rdy(int'(s2)));
    endfunction

    // Applies the edge that just happened, using the inputs that were held before it.
    task automatic sync_commit();
        bit acc;
        int k[$];
        @(posedge clk);
        #1;
        if (rst) begin
            inflight.delete();
            m_ldv = 0;
            m_ldd = 0;
            m_uf  = 0;
        end else begin
            acc = iv && !m_hazard();
            if (wbe) begin
                k = inflight.find_first_index(x) with (x == int'(wbd));
                if (k.size() > 0) inflight.delete(k[0]);
                else m_uf = 1;
            end
            if (acc && iwb) inflight.push_back(int'(id));
            m_ldv = acc && ild && iwb;
            if (m_ldv) m_ldd = int'(id);
        end
    endtask

    task automatic apply(string nm, bit r, bit f, bit v, bit w, bit l, int d, int a, int b,
                         bit u, bit we, int wd);
        exp_t e;
        rst = r; fe = f; iv = v; iwb = w; ild = l; id = 4'(d);
        s1 = 4'(a); s2 = 4'(b); us2 = u; wbe = we; wbd = 4'(wd);
        e.nm = nm;
        e.hz = m_hazard();
        for (int i = 0; i < 16; i++) e.bm[i] = cnt_of(i) > 0;
        e.uf = m_uf;
        sb.push_back(e);
    endtask

    task automatic drive(string nm, bit r, bit f, bit v, bit w, bit l, int d, int a, int b,
                         bit u, bit we, int wd);
        sync_commit();
        apply(nm, r, f, v, w, l, d, a, b, u, we, wd);
    endtask

    task automatic idle(string nm, bit f);
        drive(nm, 0, f, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                tests++;
                if (hz !== e.hz) begin
                    failed++;
                    $display("FAIL %s hazard: got %0b expected %0b", e.nm, hz, e.hz);
                end
                tests++;
                if (bm !== e.bm) begin
                    failed++;
                    $display("FAIL %s busy_mask: got %h expected %h", e.nm, bm, e.bm);
                end
                tests++;
                if (uf !== e.uf) begin
                    failed++;
                    $display("FAIL %s underflow_err: got %0b expected %0b", e.nm, uf, e.uf);
                end
            end
        end
    end

    initial begin
        int d, a, b, wd;
        bit we;
        repeat (2) @(posedge clk);
        repeat (2) idle("reset_idle", 0);
        drive("r3_issue", 0, 0, 1, 1, 0, 3, 0, 0, 0, 0, 0);
        repeat (2) drive("r3_stall", 0, 0, 1, 0, 0, 0, 3, 0, 0, 0, 0);
        drive("r3_wb", 0, 0, 1, 0, 0, 0, 3, 0, 0, 1, 3);
        idle("r3_after", 0);
        repeat (3) drive("r5_issue", 0, 0, 1, 1, 0, 5, 0, 0, 0, 0, 0);
        drive("r5_full", 0, 0, 1, 1, 0, 5, 0, 0, 0, 0, 0);
        repeat (3) drive("r5_ret", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5);
        idle("r5_empty", 0);
        drive("ld_issue", 0, 1, 1, 1, 1, 2, 0, 0, 0, 0, 0);
        repeat (2) drive("ld_use", 0, 1, 1, 0, 0, 0, 0, 2, 1, 0, 0);
        drive("ld_ret", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        drive("alu_issue", 0, 1, 1, 1, 0, 2, 0, 0, 0, 0, 0);
        drive("alu_use", 0, 1, 1, 0, 0, 0, 2, 0, 0, 0, 0);
        drive("alu_ret", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        drive("r7_issue", 0, 0, 1, 1, 0, 7, 0, 0, 0, 0, 0);
        drive("r7_same", 0, 0, 1, 1, 0, 7, 0, 0, 0, 1, 7);
        idle("r7_hold", 0);
        drive("r7_ret", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
        idle("r7_empty", 0);
        drive("uf_r9", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
        repeat (2) idle("uf_hold", 0);
        drive("uf_rst", 1, 0, 1, 1, 0, 4, 0, 0, 0, 0, 0);
        idle("post_rst", 0);
        for (int n = 0; n < 3000; n++) begin
            sync_commit();
            d  = ($urandom % 2) ? $urandom_range(0, 3) : $urandom_range(0, 15);
            a  = ($urandom % 2) ? $urandom_range(0, 3) : $urandom_range(0, 15);
            b  = ($urandom % 2) ? $urandom_range(0, 3) : $urandom_range(0, 15);
            we = inflight.size() > 0 && ($urandom % 3 != 0);
            wd = we ? inflight[$urandom_range(0, inflight.size() - 1)] : 0;
            apply("rand", $urandom_range(0, 199) == 0, $urandom % 2, $urandom % 4 != 0,
                  $urandom % 4 != 0, $urandom % 3 == 0, d, a, b, $urandom % 2, we, wd);
        end
        idle("final", 0);
        repeat (2) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
